// File: rtl/qed_dup_sequencer.sv
// QED duplicate-phase sequencer: counts originals, runs the duplicate phase, drains, then pulses qed_check.
// Optional watchdog abort of a stuck duplicate phase is built when QED_DUP_TIMEOUT_EN is defined.
module qed_dup_sequencer #(
  parameter int MAX_ORIG     = 16,
  parameter int CNT_W        = 5,
  parameter int DRAIN_CYCLES = 5,
  parameter int TIMEOUT      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             fetch_vld,
  input  logic             stall_IF,
  input  logic             dup_vld,
  input  logic             dup_req,
  output logic             exec_dup,
  output logic             qed_hold,
  output logic             qed_check,
  output logic [CNT_W-1:0] orig_cnt,
  output logic             dup_timeout
);

  typedef enum logic [1:0] {ORIG, DUP, DRAIN, CHECK} state_t;

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   MAX_C      = CNT_W'(MAX_ORIG);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   dup_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               orig_fire;
  logic               dup_fire;
  logic [CNT_W-1:0]   orig_next;
  logic [CNT_W-1:0]   dup_next;
  logic               wd_expire;

  assign orig_fire = ena & fetch_vld & ~stall_IF & (state == ORIG);
  assign dup_fire  = ena & dup_vld & ~stall_IF & (state == DUP);
  assign orig_next = orig_cnt + CNT_W'(orig_fire);
  assign dup_next  = dup_cnt + CNT_W'(dup_fire);

`ifdef QED_DUP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  // Expires on the TIMEOUT-th consecutive duplicate-phase cycle without progress.
  assign wd_expire = (state == DUP) & ~dup_fire & (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign wd_expire   = 1'b0;
  assign dup_timeout = 1'b0;
`endif

  // NOTE: all state and outputs are updated with non-blocking assignments so every
  // branch reads the pre-edge values; a blocking update here would leak same-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ORIG;
      exec_dup  <= 1'b0;
      qed_hold  <= 1'b0;
      qed_check <= 1'b0;
      orig_cnt  <= '0;
      dup_cnt   <= '0;
      drain_cnt <= '0;
`ifdef QED_DUP_TIMEOUT_EN
      dup_timeout <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else if (!ena || wd_expire) begin
      // Partial sequences are discarded; only the sticky timeout flag survives.
      state     <= ORIG;
      exec_dup  <= 1'b0;
      qed_hold  <= 1'b0;
      qed_check <= 1'b0;
      orig_cnt  <= '0;
      dup_cnt   <= '0;
      drain_cnt <= '0;
`ifdef QED_DUP_TIMEOUT_EN
      wd_cnt <= '0;
      if (wd_expire) dup_timeout <= 1'b1;
`endif
    end else begin
`ifdef QED_DUP_TIMEOUT_EN
      wd_cnt <= '0;
`endif
      unique case (state)
        ORIG: begin
          orig_cnt <= orig_next;
          if (orig_next == MAX_C || (dup_req && orig_cnt != '0)) begin
            state    <= DUP;
            exec_dup <= 1'b1;
          end
        end
        DUP: begin
          dup_cnt <= dup_next;
`ifdef QED_DUP_TIMEOUT_EN
          wd_cnt <= dup_fire ? '0 : wd_cnt + 1'b1;
`endif
          if (dup_next == orig_cnt) begin
            state     <= DRAIN;
            qed_hold  <= 1'b1;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= CHECK;
            exec_dup  <= 1'b0;
            qed_hold  <= 1'b0;
            qed_check <= 1'b1;
            orig_cnt  <= '0;
            dup_cnt   <= '0;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        CHECK: begin
          state     <= ORIG;
          qed_check <= 1'b0;
        end
        default: state <= ORIG;
      endcase
    end
  end

endmodule
